// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the digit-serial subtractor.
// The master issues operands and the slave (the subtractor) returns the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor computing diff = a - b - bin over WIDTH bits,
// DIGIT bits per clock, least-significant digit first, with a registered borrow.
module serial_subtractor #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 1,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_subtractor_if.slave bus
);

  localparam int N      = WIDTH / DIGIT;
  localparam int CW_RAW = $clog2(N + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_badParam
    $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_lastDigit;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_aMsb;
  logic             r_bMsb;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [DIGIT:0]   w_digit;
  logic             w_nb;
  logic [WIDTH-1:0] w_workNext;
  logic             w_ovfNext;

  assign w_digit = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, r_borrow};
  assign w_nb    = w_digit[DIGIT];

  // New digits enter at the MSB end so the result lands in place after N steps.
  if (DIGIT == WIDTH) begin : g_fullDigit
    assign w_workNext = w_digit[DIGIT-1:0];
  end else begin : g_shiftDigit
    assign w_workNext = {w_digit[DIGIT-1:0], r_work[WIDTH-1:DIGIT]};
  end

  assign w_ovfNext = (SIGNED != 0) && (r_aMsb != r_bMsb)
                     && (w_workNext[WIDTH-1] != r_aMsb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_lastDigit = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST) begin
          w_lastDigit = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Result registers only load on the final digit, so they hold through RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_aMsb   <= 1'b0;
      r_bMsb   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_borrow <= bus.bin;
      r_cnt    <= '0;
      r_aMsb   <= bus.a[WIDTH-1];
      r_bMsb   <= bus.b[WIDTH-1];
    end else if (r_state == RUN) begin
      r_work   <= w_workNext;
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_borrow <= w_nb;
      r_cnt    <= r_cnt + 1'b1;
      if (w_lastDigit) begin
        r_diff <= w_workNext;
        r_bout <= w_nb;
        r_ovf  <= w_ovfNext;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: a bit-serial signed instance and a
// 4-bit-digit unsigned instance, driven and sampled on the falling clock edge.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] lastDiff [2];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus1 ();
  serial_subtractor_if #(.WIDTH(8)) bus4 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4), .SIGNED(0)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Packs {busy, done, bout, ovf, diff} of the selected instance.
  function automatic logic [11:0] obs(input int sel);
    if (sel == 4) return {bus4.busy, bus4.done, bus4.bout, bus4.ovf, bus4.diff};
    return {bus1.busy, bus1.done, bus1.bout, bus1.ovf, bus1.diff};
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic applyStimulus(input int sel, input logic [7:0] a,
                               input logic [7:0] b, input logic bin);
    if (sel == 4) begin
      bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.bin = bin;
    end else begin
      bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.bin = bin;
    end
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  task automatic waitResult(input int sel, input string tag, input int firstCycle,
                            input logic [7:0] expDiff, input logic expBout,
                            input logic expOvf);
    int          n      = (sel == 4) ? 2 : 8;
    int          idx    = (sel == 4) ? 1 : 0;
    int          cycles = firstCycle;
    logic [11:0] o;
    o = obs(sel);
    checkOutput({tag, "/busy"}, 32'(o[11]), 32'd1);
    checkOutput({tag, "/hold"}, 32'(o[7:0]), 32'(lastDiff[idx]));
    while (!o[10] && cycles < 40) begin
      @(negedge clk);
      cycles++;
      o = obs(sel);
    end
    checkOutput({tag, "/latency"}, 32'(cycles), 32'(n + 1));
    checkOutput({tag, "/doneBusy"}, 32'(o[11]), 32'd0);
    checkOutput({tag, "/diff"}, 32'(o[7:0]), 32'(expDiff));
    checkOutput({tag, "/bout"}, 32'(o[9]), 32'(expBout));
    checkOutput({tag, "/ovf"}, 32'(o[8]), 32'(expOvf));
    lastDiff[idx] = expDiff;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rbin;
    logic [8:0] model;
    logic       mOvf;

    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    lastDiff[0] = 8'h00;
    lastDiff[1] = 8'h00;
    #12;
    checkOutput("reset/dut1", 32'(obs(1)), 32'h0);
    checkOutput("reset/dut4", 32'(obs(4)), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] directed vectors");

    applyStimulus(1, 8'h05, 8'h03, 1'b0);
    waitResult(1, "5m3", 1, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle/done", 32'(obs(1) >> 10), 32'd0);

    applyStimulus(1, 8'h03, 8'h05, 1'b0);
    waitResult(1, "3m5", 1, 8'hFE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1, 8'h00, 8'h00, 1'b1);
    waitResult(1, "0m0b1", 1, 8'hFF, 1'b1, 1'b0);

    // Back-to-back: each new start lands in the DONE cycle.
    applyStimulus(1, 8'h80, 8'h01, 1'b0);
    waitResult(1, "ovfNeg", 1, 8'h7F, 1'b0, 1'b1);
    applyStimulus(1, 8'h7F, 8'hFF, 1'b0);
    waitResult(1, "ovfPos", 1, 8'h80, 1'b1, 1'b1);

    @(negedge clk);
    applyStimulus(4, 8'hA3, 8'h5C, 1'b1);
    waitResult(4, "d4A3", 1, 8'h46, 1'b0, 1'b0);
    applyStimulus(4, 8'h80, 8'h01, 1'b0);
    waitResult(4, "d4unsigned", 1, 8'h7F, 1'b0, 1'b0);
    applyStimulus(4, 8'h00, 8'h01, 1'b0);
    waitResult(4, "d4wrap", 1, 8'hFF, 1'b1, 1'b0);

    @(negedge clk);
    applyStimulus(1, 8'h10, 8'h01, 1'b0);
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = 8'hFF; bus1.b = 8'h00; bus1.bin = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    waitResult(1, "ignoreBusy", 3, 8'h0F, 1'b0, 1'b0);

    @(negedge clk);
    applyStimulus(1, 8'h55, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort/dut1", 32'(obs(1)), 32'h0);
    checkOutput("abort/dut4", 32'(obs(4)), 32'h0);
    lastDiff[0] = 8'h00;
    lastDiff[1] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort/noDone", 32'(obs(1) >> 10), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort/stillIdle", 32'(obs(1)), 32'h0);
    applyStimulus(1, 8'h55, 8'h22, 1'b0);
    waitResult(1, "afterReset", 1, 8'h33, 1'b0, 1'b0);

    $display("[TB] random vectors");
    for (int i = 0; i < 20; i++) begin
      for (int s = 0; s < 2; s++) begin
        int sel;
        sel   = (s == 0) ? 1 : 4;
        ra    = 8'($urandom);
        rb    = 8'($urandom);
        rbin  = 1'($urandom);
        model = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
        mOvf  = (sel == 1) && (ra[7] != rb[7]) && (model[7] != ra[7]);
        applyStimulus(sel, ra, rb, rbin);
        waitResult(sel, "rand", 1, model[7:0], model[8], mOvf);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor built from a chain of borrow-propagating subtractor cells. It computes diff = a - b - bin over WIDTH bits, processing DIGIT bits per clock, least-significant digit first, with a registered borrow between digits. It sits beside the combinational subtractor cells in the arithmetic library and serves area-constrained datapaths that can accept multi-cycle latency. It uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
SIGNED, 0, 1 = compute the two's-complement overflow flag ovf; 0 = ovf tied to 0.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a subtraction; sampled only when not busy
a  input  WIDTH  minuend; sampled on accepted start
b  input  WIDTH  subtrahend; sampled on accepted start
bin  input  1  borrow-in; sampled on accepted start
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  result register; holds the last completed result
bout  output  1  final borrow-out; high when a < b + bin (unsigned)
ovf  output  1  signed overflow of a - b - bin (SIGNED=1 only)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; operand shift registers, borrow register and digit counter cleared. Reset mid-operation aborts the operation with no done pulse. Outputs stay 0 until the next completion.
- N = WIDTH/DIGIT is the number of digit steps. The counter is ceil(log2(N+1)) bits wide, minimum 1.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, latch a, b and bin into working registers; borrow<=bin; cnt<=0; go to RUN; busy=1 from the next cycle.
- RUN, each cycle:
  - Take the low DIGIT bits of the working a and b and form {nb, d} = a_d - b_d - borrow as a (DIGIT+1)-bit subtraction. nb is the borrow-out of the digit.
  - Shift d into the MSB end of the working diff register.
  - Shift the working a and b right by DIGIT.
  - borrow<=nb; cnt<=cnt+1.
  - When cnt==N-1, go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - diff, bout and ovf are loaded from the working registers on the RUN->DONE edge, so they are valid while done=1.
  - They hold until the next completion or reset; they never change during RUN.
  - Go to IDLE. If start=1 during DONE, it is accepted exactly as in IDLE (back-to-back operation, next state RUN).
- Latency: start accepted at edge k -> done high during cycle k+N+1. Throughput: one result per N+1 cycles.
- start while busy=1 is ignored. The a, b and bin inputs are don't-care outside the accepting cycle.
- ovf (SIGNED=1): ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched operands. For SIGNED=0, ovf is constant 0.
- bout is the final borrow register value. Wrap-around is modulo 2^WIDTH: diff = (a - b - bin) mod 2^WIDTH.
- Asserting start and rst_n low together: reset wins.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0, start pulsed at cycle 0 -> busy high in cycles 1-8; done pulse in cycle 9; diff=0x02, bout=0, ovf=0.
- WIDTH=8, DIGIT=1: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Between completions, diff holds 0xFE.
- WIDTH=8, SIGNED=1: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1, bout=0. Also a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- WIDTH=8, DIGIT=4: a=0xA3, b=0x5C, bin=1 -> done in cycle 3 after start; diff=0x46, bout=0. Second start asserted in the DONE cycle -> accepted; next done 3 cycles later.
- start re-pulsed with different operands while busy -> ignored; the result matches the first operands only.
- rst_n driven low during RUN (cycle 4 of 8) -> busy=0, diff=0, no done pulse. A fresh start after release produces the correct result with full latency.
- Randomised: 1000 operand sets per (DIGIT=1,2,4,8, SIGNED=0/1) -> compare against a behavioural a-b-bin model.
